output_accum_buffer: RTL and testbench

Accumulation stage directly downstream of the mapping-group shift stage. It sequences the 2-bit shift count through all bit-pair positions and pulls one shifted partial sum per position. It adds the partials into a 32-bit accumulator and presents the finished multi-bit result to the next consumer through a valid/ready handshake. It replaces the open-loop read-enable accumulation with a controlled, restartable sequence.

---
 rtl/output_accum_buffer_pkg.sv | 15 +
 rtl/output_accum_buffer.sv | 97 +++++++++
 tb/tb_output_accum_buffer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_accum_buffer_pkg.sv
// Shared types and defaults for the output accumulation buffer.
// Holds the FSM state encoding and the default sizing constants.
package output_accum_buffer_pkg;

  localparam int OAB_DATA_W = 32;
  localparam int OAB_STEPS  = 4;
  localparam int OAB_CNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } oab_state_e;

endpackage

// File: rtl/output_accum_buffer.sv
// Sequences the shift count over all bit-pair positions, sums one partial per
// position and hands the result downstream over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start_i; result_o holds the last result
// ACCUM | requesting partial for shift_count_o, summing on partial_valid_i
// HOLD  | result_valid_o high until result_ready_i; start_i may chain a new run
import output_accum_buffer_pkg::*;

module output_accum_buffer #(
  parameter int DATA_W = OAB_DATA_W,
  parameter int STEPS  = OAB_STEPS,
  parameter int CNT_W  = OAB_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DATA_W-1:0] partial_i,
  input  logic              partial_valid_i,
  output logic [CNT_W-1:0]  shift_count_o,
  output logic              rd_en_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] result_o,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic              ovf_o
);

  if ((2 ** CNT_W) < STEPS) begin : g_cnt_w_check
    $error("output_accum_buffer: CNT_W too narrow for STEPS");
  end

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  oab_state_e        state_q;
  logic [CNT_W-1:0]  step_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W:0]   sum_w;

  // Extra bit captures the carry-out feeding the sticky overflow flag.
  assign sum_w = {1'b0, acc_q} + {1'b0, partial_i};

  assign shift_count_o = step_q;
  assign rd_en_o       = (state_q == ACCUM);
  assign busy_o        = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      step_q         <= '0;
      acc_q          <= '0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      ovf_o          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            acc_q   <= '0;
            step_q  <= '0;
            ovf_o   <= 1'b0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (partial_valid_i) begin
            acc_q <= sum_w[DATA_W-1:0];
            ovf_o <= ovf_o | sum_w[DATA_W];
            if (step_q == LAST_STEP) begin
              result_o       <= sum_w[DATA_W-1:0];
              result_valid_o <= 1'b1;
              step_q         <= '0;
              state_q        <= HOLD;
            end else begin
              step_q <= step_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (result_ready_i) begin
            result_valid_o <= 1'b0;
            if (start_i) begin
              acc_q   <= '0;
              step_q  <= '0;
              ovf_o   <= 1'b0;
              state_q <= ACCUM;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_accum_buffer.sv
// Self-checking bench for output_accum_buffer: 32-bit default instance plus an
// 8-bit instance for carry-out behaviour, checked against a plain-sum model.
module tb_output_accum_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;

  logic        start, valid, ready;
  logic [31:0] partial;
  logic [1:0]  shift;
  logic        rd_en, busy, rvalid, ovf;
  logic [31:0] result;

  logic        start8, valid8, ready8;
  logic [7:0]  partial8;
  logic [1:0]  shift8;
  logic        rd_en8, busy8, rvalid8, ovf8;
  logic [7:0]  result8;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] parts[4];

  always #5 clk_i = ~clk_i;

  output_accum_buffer u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start), .partial_i(partial),
    .partial_valid_i(valid), .shift_count_o(shift), .rd_en_o(rd_en),
    .busy_o(busy), .result_o(result), .result_valid_o(rvalid),
    .result_ready_i(ready), .ovf_o(ovf)
  );

  output_accum_buffer #(.DATA_W(8)) u_dut8 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start8), .partial_i(partial8),
    .partial_valid_i(valid8), .shift_count_o(shift8), .rd_en_o(rd_en8),
    .busy_o(busy8), .result_o(result8), .result_valid_o(rvalid8),
    .result_ready_i(ready8), .ovf_o(ovf8)
  );

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // One full run on the 32-bit instance using parts[]; expectations come from a
  // wide integer sum of the four partials.
  task automatic accum32(input bit do_start, input int gap, input int ready_delay,
                         input bit do_accept, input bit poke_start);
    longint     s;
    logic [31:0] exp_res;
    logic        exp_ovf;
    s = 0;
    for (int k = 0; k < 4; k++) s += longint'(parts[k]);
    exp_res = s[31:0];
    exp_ovf = (s > 64'h0000_0000_FFFF_FFFF);

    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    n_tests++;
    if ({busy, rd_en, rvalid} !== 3'b110) begin
      n_fail++;
      $display("FAIL accum_entry: busy/rd_en/valid=%b want 110", {busy, rd_en, rvalid});
    end
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        valid   = 1'b0;
        partial = $urandom;
        n_tests++;
        if (shift !== 2'(k)) begin
          n_fail++;
          $display("FAIL gap_shift_hold: got %0d want %0d", shift, k);
        end
        tick();
      end
      valid   = 1'b1;
      partial = parts[k];
      if (poke_start && k == 1) start = 1'b1;
      n_tests++;
      if (shift !== 2'(k) || rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL step_shift: shift=%0d valid=%b want %0d/0", shift, rvalid, k);
      end
      tick();
      valid = 1'b0;
      start = 1'b0;
    end
    n_tests++;
    if (rvalid !== 1'b1 || result !== exp_res || ovf !== exp_ovf || busy !== 1'b1 || rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_result: valid=%b result=%h ovf=%b busy=%b rd_en=%b want 1/%h/%b/1/0",
               rvalid, result, ovf, busy, rd_en, exp_res, exp_ovf);
    end
    for (int d = 0; d < ready_delay; d++) begin
      ready   = 1'b0;
      valid   = 1'b1;
      partial = $urandom;
      if (poke_start) start = 1'b1;
      tick();
      start = 1'b0;
      valid = 1'b0;
      n_tests++;
      if (rvalid !== 1'b1 || result !== exp_res || ovf !== exp_ovf || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure: valid=%b result=%h ovf=%b want 1/%h/%b", rvalid, result, ovf, exp_res, exp_ovf);
      end
    end
    if (do_accept) begin
      ready = 1'b1;
      tick();
      ready = 1'b0;
      n_tests++;
      if (rvalid !== 1'b0 || busy !== 1'b0 || result !== exp_res) begin
        n_fail++;
        $display("FAIL accept: valid=%b busy=%b result=%h want 0/0/%h", rvalid, busy, result, exp_res);
      end
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    start = 0; valid = 0; ready = 0; partial = '0;
    start8 = 0; valid8 = 0; ready8 = 0; partial8 = '0;
    #2;
    n_tests++;
    if ({shift, rd_en, busy, rvalid, ovf} !== 6'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset32: shift=%0d rd_en=%b busy=%b valid=%b ovf=%b result=%h want all 0",
               shift, rd_en, busy, rvalid, ovf, result);
    end
    n_tests++;
    if ({shift8, rd_en8, busy8, rvalid8, ovf8} !== 6'b0 || result8 !== 8'h0) begin
      n_fail++;
      $display("FAIL reset8: got busy=%b valid=%b result=%h want 0/0/00", busy8, rvalid8, result8);
    end
    tick();
    rst_ni = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b want 0", busy);
    end
  endtask

  task automatic test_basic;
    parts = '{32'h10, 32'h20, 32'h30, 32'h40};
    accum32(1, 0, 0, 1, 0);
    n_tests++;
    if (result !== 32'hA0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: result=%h ovf=%b want 000000a0/0", result, ovf);
    end
  endtask

  task automatic test_gapped;
    parts = '{32'hFFFC0, 32'hFFFC0, 32'hFFFC0, 32'hFFFC0};
    accum32(1, 1, 3, 1, 0);
    n_tests++;
    if (result !== 32'h3FFF00) begin
      n_fail++;
      $display("FAIL gapped_result: result=%h want 003fff00", result);
    end
  endtask

  task automatic test_start_on_accept;
    parts = '{32'h5, 32'h6, 32'h7, 32'h8};
    accum32(1, 0, 1, 0, 0);
    ready = 1'b1;
    start = 1'b1;
    tick();
    ready = 1'b0;
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || rd_en !== 1'b1 || rvalid !== 1'b0 || shift !== 2'd0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL chain_entry: busy=%b rd_en=%b valid=%b shift=%0d ovf=%b want 1/1/0/0/0",
               busy, rd_en, rvalid, shift, ovf);
    end
    parts = '{32'h1, 32'h2, 32'h3, 32'h4};
    accum32(0, 0, 0, 1, 0);
    n_tests++;
    if (result !== 32'hA) begin
      n_fail++;
      $display("FAIL chain_result: result=%h want 0000000a", result);
    end
  endtask

  task automatic test_overflow8;
    logic [7:0] p8[4];
    p8 = '{8'h80, 8'h80, 8'h01, 8'h00};
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid8   = 1'b1;
      partial8 = p8[k];
      tick();
    end
    valid8 = 1'b0;
    n_tests++;
    if (rvalid8 !== 1'b1 || result8 !== 8'h01 || ovf8 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf8_result: valid=%b result=%h ovf=%b want 1/01/1", rvalid8, result8, ovf8);
    end
    ready8 = 1'b1;
    tick();
    ready8 = 1'b0;
    n_tests++;
    if (busy8 !== 1'b0 || ovf8 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf8_sticky_idle: busy=%b ovf=%b want 0/1", busy8, ovf8);
    end
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n_tests++;
    if (ovf8 !== 1'b0 || busy8 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf8_clear_on_start: ovf=%b busy=%b want 0/1", ovf8, busy8);
    end
    for (int k = 0; k < 4; k++) begin
      valid8   = 1'b1;
      partial8 = 8'h3;
      tick();
    end
    valid8 = 1'b0;
    ready8 = 1'b1;
    tick();
    ready8 = 1'b0;
    n_tests++;
    if (result8 !== 8'h0C || ovf8 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf8_second: result=%h ovf=%b busy=%b want 0c/0/0", result8, ovf8, busy8);
    end
  endtask

  task automatic test_reset_mid;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      valid   = 1'b1;
      partial = 32'h100;
      tick();
    end
    valid  = 1'b0;
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if ({shift, rd_en, busy, rvalid, ovf} !== 6'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: shift=%0d rd_en=%b busy=%b valid=%b ovf=%b result=%h want all 0",
               shift, rd_en, busy, rvalid, ovf, result);
    end
    tick();
    rst_ni = 1'b1;
    tick();
    parts = '{32'h1, 32'h1, 32'h1, 32'h1};
    accum32(1, 0, 0, 1, 0);
    n_tests++;
    if (result !== 32'h4) begin
      n_fail++;
      $display("FAIL reset_mid_rerun: result=%h want 00000004", result);
    end
  endtask

  task automatic test_ignored_start;
    for (int k = 0; k < 4; k++) parts[k] = $urandom_range(0, 32'hFFFC0);
    accum32(1, 1, 2, 1, 1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < 4; k++)
        parts[k] = (i % 2 == 0) ? $urandom_range(0, 32'hFFFC0) : $urandom;
      accum32(1, $urandom_range(0, 2), $urandom_range(0, 3), 1, 0);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_start_on_accept();
    test_overflow8();
    test_reset_mid();
    test_ignored_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
